// File: rtl/switch_display_debounced_pkg.sv
// Shared constants for the debounced switch display: active-low 7-segment codes,
// display-mode encoding and the nibble-to-segment lookup.
package switch_display_pkg;

    // Segment codes are {dp,g,f,e,d,c,b,a}, active-low, with dp off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_COUNT = 1'b1
    } display_mode_e;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] value);
        logic [7:0] seg;
        unique case (value)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/switch_display_debounced_if.sv
// Board-facing bundle of the switch display: switch/mode/clear inputs and
// LED/7-segment outputs. The board (or bench) is master, the display block is slave.
interface switch_display_debounced_if #(
    parameter int CHANNELS = 6
);
    logic [CHANNELS-1:0]   SW;
    logic                  MODE;
    logic                  CLEAR;
    logic [CHANNELS-1:0]   LEDR;
    logic [8*CHANNELS-1:0] HEX;

    modport master (
        output SW, MODE, CLEAR,
        input  LEDR, HEX
    );

    modport slave (
        input  SW, MODE, CLEAR,
        output LEDR, HEX
    );
endinterface

// File: rtl/switch_display_debounced_debouncer.sv
// One switch channel: 2-FF synchroniser followed by a restart-on-glitch debouncer.
// rise is a combinational strobe, high in the cycle that stable is about to go 0->1.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic raw,
    output logic stable,
    output logic busy,
    output logic rise
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;
    logic             settle;

    assign settle = (sync2 != stable) && (count == LAST);
    assign busy   = (count != '0);
    assign rise   = settle && sync2;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser to one stage.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                count <= '0;
            end else if (settle) begin
                stable <= sync2;
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_display_debounced.sv
// N-channel debounced switch display: LEDs follow the debounced switches, each digit
// shows the level or a mod-16 count of debounced presses, dp marks a settling channel.
module switch_display_debounced
    import switch_display_pkg::*;
#(
    parameter int CHANNELS        = 6,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET,
    switch_display_debounced_if.slave   sd
);

    logic [CHANNELS-1:0] stable;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] rise;
    logic [3:0]          edge_cnt [CHANNELS];
    logic [7:0]          digit_d  [CHANNELS];
    logic [7:0]          digit_q  [CHANNELS];
    logic [CHANNELS-1:0] ledr_q;
    display_mode_e       mode;

    assign mode = display_mode_e'(sd.MODE);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        switch_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debouncer (
            .CLOCK_50 (CLOCK_50),
            .RESET    (RESET),
            .raw      (sd.SW[g]),
            .stable   (stable[g]),
            .busy     (busy[g]),
            .rise     (rise[g])
        );

        assign sd.HEX[8*g +: 8] = digit_q[g];
    end

    assign sd.LEDR = ledr_q;

    // NOTE: every digit_d element is fully assigned on each pass, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (mode == MODE_COUNT) begin
                digit_d[i] = hex_to_seg(edge_cnt[i]);
            end else begin
                digit_d[i] = stable[i] ? SEG_1 : SEG_0;
            end
            digit_d[i][7] = ~busy[i];
        end
    end

    // CLEAR takes priority over a coincident press, so that press is not counted.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            ledr_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                edge_cnt[i] <= 4'h0;
                digit_q[i]  <= SEG_0;
            end
        end else begin
            ledr_q <= stable;
            for (int i = 0; i < CHANNELS; i++) begin
                if (sd.CLEAR) begin
                    edge_cnt[i] <= 4'h0;
                end else if (rise[i]) begin
                    edge_cnt[i] <= edge_cnt[i] + 4'h1;
                end
                digit_q[i] <= digit_d[i];
            end
        end
    end

endmodule

// File: tb/tb_switch_display_debounced.sv
// Randomised self-checking bench for switch_display_debounced with directed scenarios
// (latency, bounce, count wrap, CLEAR race, mode toggling, async reset).
module tb_switch_display_debounced;

    localparam int CH = 6;
    localparam int DC = 4;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    switch_display_debounced_if #(.CHANNELS(CH)) sd_if ();

    switch_display_debounced #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (4)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .sd       (sd_if)
    );

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a channel commits once its last DC synchronised samples all
    // disagree with the committed level; outputs are that state one cycle later.
    logic          m_s1     [CH];
    logic          m_s2     [CH];
    logic          m_hist   [CH][DC];
    logic          m_stable [CH];
    logic          m_busy   [CH];
    logic [3:0]    m_cnt    [CH];
    logic [CH-1:0]   m_led;
    logic [8*CH-1:0] m_hex;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_busy[i] = 0; m_cnt[i] = 0;
            for (int k = 0; k < DC; k++) m_hist[i][k] = 0;
        end
        m_led = '0;
        m_hex = {CH{8'hC0}};
    endtask

    task automatic model_step();
        for (int i = 0; i < CH; i++) begin
            logic       sample, commit, old_stable, old_busy;
            logic [3:0] old_cnt;
            logic [7:0] digit;
            sample     = m_s2[i];
            old_stable = m_stable[i];
            old_busy   = m_busy[i];
            old_cnt    = m_cnt[i];
            for (int k = DC - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = sample;
            commit = 1'b1;
            for (int k = 0; k < DC; k++) if (m_hist[i][k] == old_stable) commit = 1'b0;

            m_led[i] = old_stable;
            digit = sd_if.MODE ? seg_tab[old_cnt] : (old_stable ? 8'hF9 : 8'hC0);
            if (old_busy) digit[7] = 1'b0;
            m_hex[8*i +: 8] = digit;

            if (commit) m_stable[i] = ~old_stable;
            m_busy[i] = (sample != m_stable[i]);
            if (sd_if.CLEAR) m_cnt[i] = 4'h0;
            else if (commit && !old_stable) m_cnt[i] = old_cnt + 4'h1;

            m_s2[i] = m_s1[i];
            m_s1[i] = sd_if.SW[i];
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        if (RESET) model_reset();
        else       model_step();
        @(negedge CLOCK_50);
        check("ledr", sd_if.LEDR, m_led);
        check("hex", sd_if.HEX, m_hex);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int ch, input int hold);
        sd_if.SW[ch] = 1'b1;
        ticks(hold);
        sd_if.SW[ch] = 1'b0;
        ticks(hold);
    endtask

    initial begin
        int  dp_seen, rises;
        logic prev;
        model_reset();
        sd_if.SW = '0; sd_if.MODE = 1'b0; sd_if.CLEAR = 1'b0;

        RESET = 1'b1;
        ticks(3);
        check("rst_ledr", sd_if.LEDR, 0);
        check("rst_hex", sd_if.HEX, {CH{8'hC0}});
        RESET = 1'b0;
        ticks(2);

        // Clean press: LEDR follows 7 cycles after the raw edge
        sd_if.SW[2] = 1'b1;
        ticks(6);
        check("press_lat6", sd_if.LEDR[2], 0);
        tick();
        check("press_lat7", sd_if.LEDR[2], 1);
        check("press_digit2", sd_if.HEX[23:16], 8'hF9);
        ticks(3);

        // Bounce on channel 0
        dp_seen = 0; rises = 0; prev = sd_if.LEDR[0];
        for (int s = 0; s < 4; s++) begin
            sd_if.SW[0] = (s % 2 == 0);
            for (int t = 0; t < 2; t++) begin
                tick();
                check("bounce_no_led", sd_if.LEDR[0], 0);
                if (sd_if.HEX[7] == 1'b0) dp_seen = 1;
            end
        end
        sd_if.SW[0] = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (sd_if.HEX[7] == 1'b0) dp_seen = 1;
            if (sd_if.LEDR[0] && !prev) rises++;
            prev = sd_if.LEDR[0];
        end
        check("bounce_dp_seen", dp_seen, 1);
        check("bounce_one_rise", rises, 1);
        sd_if.MODE = 1'b1;
        tick();
        check("bounce_count1", sd_if.HEX[7:0], 8'hF9);
        sd_if.SW[0] = 1'b0;
        ticks(10);

        // 17 presses on channel 5: counts through F and wraps
        for (int k = 1; k <= 17; k++) begin
            press(5, 9);
            check("count_wrap5", sd_if.HEX[47:40], seg_tab[k % 16]);
        end

        // CLEAR coincident with the committing edge wins
        press(1, 9);
        check("clear_pre", sd_if.HEX[15:8], 8'hF9);
        sd_if.SW[1] = 1'b1;
        ticks(5);
        sd_if.CLEAR = 1'b1;
        tick();
        sd_if.CLEAR = 1'b0;
        ticks(3);
        check("clear_race_led", sd_if.LEDR[1], 1);
        check("clear_race_digit", sd_if.HEX[15:8], 8'hC0);
        sd_if.SW[1] = 1'b0;
        ticks(9);
        press(1, 9);
        check("clear_next", sd_if.HEX[15:8], 8'hF9);

        // Mode toggle with count A on channel 3
        for (int k = 0; k < 9; k++) press(3, 9);
        sd_if.SW[3] = 1'b1;
        ticks(9);
        check("mode_count_a", sd_if.HEX[31:24], 8'h88);
        sd_if.MODE = 1'b0;
        tick();
        check("mode_level", sd_if.HEX[31:24], 8'hF9);
        sd_if.MODE = 1'b1;
        tick();
        check("mode_count_again", sd_if.HEX[31:24], 8'h88);
        sd_if.SW[3] = 1'b0;
        ticks(9);

        // Random phase with a mid-bounce asynchronous reset
        for (int it = 0; it < 300; it++) begin
            if (it == 150) begin
                for (int b = 0; b < 3; b++) begin
                    sd_if.SW = sd_if.SW ^ 6'h3F;
                    tick();
                end
                #1;
                RESET = 1'b1;
                #1;
                check("async_rst_ledr", sd_if.LEDR, 0);
                check("async_rst_hex", sd_if.HEX, {CH{8'hC0}});
                ticks(2);
                RESET = 1'b0;
            end
            sd_if.SW = sd_if.SW ^ 6'($urandom_range(1, 63));
            if ($urandom_range(0, 7) == 0) sd_if.MODE = 1'($urandom);
            sd_if.CLEAR = ($urandom_range(0, 15) == 0);
            tick();
            sd_if.CLEAR = 1'b0;
            ticks($urandom_range(0, 7));
        end
        ticks(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
